// File: rtl/squat_switch.sv
// ATM cell switch: receives UNI cells round-robin from the Rx ports, checks the HEC,
// translates the VPI through a CPU-written table and re-sends the NNI cell on each masked Tx port.
module squat_switch #(
    parameter int NumRx = 4,
    parameter int NumTx = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*NumRx-1:0] rx_data,
    input  logic [NumRx-1:0]   rx_soc,
    input  logic [NumRx-1:0]   rx_clav,
    output logic [NumRx-1:0]   rx_en,
    output logic [8*NumTx-1:0] tx_data,
    output logic [NumTx-1:0]   tx_soc,
    output logic [NumTx-1:0]   tx_en,
    input  logic [NumTx-1:0]   tx_clav,
    input  logic               cpu_sel,
    input  logic               cpu_wr,
    input  logic [7:0]         cpu_addr,
    input  logic [15:0]        cpu_wdata,
    output logic [15:0]        cpu_rdata,
    output logic               cpu_rdy
);

    localparam int         PW         = 2;
    localparam logic [5:0] LAST_BYTE  = 6'd52;
    localparam logic [5:0] HDR_LEN    = 6'd5;
    localparam int         TxMaskInt  = (1 << NumTx) - 1;
    localparam logic [3:0] TX_VALID   = TxMaskInt[3:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_CHECK,
        S_LOOKUP,
        S_TX_SEL,
        S_TX_WAIT,
        S_SEND
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [5:0]      r_cnt;
    logic [PW-1:0]   r_rx_port;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_tx_port;
    logic [3:0]      r_mask;
    logic [11:0]     r_vpi12;
    logic [7:0]      r_hdr [0:4];
    logic [7:0]      r_pay [0:47];
    logic [15:0]     r_lut [0:255];
    logic [15:0]     r_cpu_rdata;
    logic            r_cpu_rdy;

    logic [7:0]      w_rx_lane [NumRx];
    logic [7:0]      w_rx_sel_byte;
    logic            w_rx_sel_soc;
    logic            w_rx_found;
    logic [PW-1:0]   w_rx_pick;
    logic [PW-1:0]   w_cand;
    logic            w_tx_any;
    logic [PW-1:0]   w_tx_pick;
    logic [7:0]      w_vpi8;
    logic [7:0]      w_hec_rx;
    logic [7:0]      w_hec_tx;
    logic [5:0]      w_pay_idx;
    logic [7:0]      w_tx_byte;

    // CRC-8 (x^8+x^2+x+1), bit-serial MSB-first over the four header bytes, coset 0x55.
    function automatic logic [7:0] hec_calc(input logic [31:0] hdr);
        logic [7:0] crc;
        crc = 8'h00;
        for (int b = 31; b >= 0; b--) begin
            if (crc[7] ^ hdr[b]) crc = {crc[6:0], 1'b0} ^ 8'h07;
            else                 crc = {crc[6:0], 1'b0};
        end
        return crc ^ 8'h55;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NumRx; gi++) begin : g_rx
            assign w_rx_lane[gi] = rx_data[8*gi +: 8];
            assign rx_en[gi]     = ~((r_state == S_RECV) && (r_rx_port == PW'(gi)));
        end
        for (gi = 0; gi < NumTx; gi++) begin : g_tx
            logic w_act;
            assign w_act              = (r_state == S_SEND) && (r_tx_port == PW'(gi));
            assign tx_en[gi]          = ~w_act;
            assign tx_soc[gi]         = w_act && (r_cnt == 6'd0);
            assign tx_data[8*gi +: 8] = w_act ? w_tx_byte : 8'h00;
        end
    endgenerate

    assign w_rx_sel_byte = w_rx_lane[r_rx_port];
    assign w_rx_sel_soc  = rx_soc[r_rx_port];
    assign w_vpi8        = {r_hdr[0][3:0], r_hdr[1][7:4]};
    assign w_hec_rx      = hec_calc({r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3]});
    assign w_hec_tx      = hec_calc({r_vpi12, r_hdr[1][3:0], r_hdr[2], r_hdr[3]});
    assign w_pay_idx     = r_cnt - HDR_LEN;
    assign cpu_rdata     = r_cpu_rdata;
    assign cpu_rdy       = r_cpu_rdy;

    // Round-robin: the first port with a cell, searching from r_rr_ptr upward.
    always_comb begin
        w_rx_found = 1'b0;
        w_rx_pick  = '0;
        w_cand     = '0;
        for (int k = NumRx - 1; k >= 0; k--) begin
            w_cand = PW'((int'(r_rr_ptr) + k) % NumRx);
            if (rx_clav[w_cand]) begin
                w_rx_found = 1'b1;
                w_rx_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_tx_any  = 1'b0;
        w_tx_pick = '0;
        for (int k = NumTx - 1; k >= 0; k--) begin
            if (r_mask[k]) begin
                w_tx_any  = 1'b1;
                w_tx_pick = PW'(k);
            end
        end
    end

    always_comb begin
        w_tx_byte = r_pay[w_pay_idx];
        if (r_cnt < HDR_LEN) begin
            case (r_cnt[2:0])
                3'd0:    w_tx_byte = r_vpi12[11:4];
                3'd1:    w_tx_byte = {r_vpi12[3:0], r_hdr[1][3:0]};
                3'd2:    w_tx_byte = r_hdr[2];
                3'd3:    w_tx_byte = r_hdr[3];
                default: w_tx_byte = w_hec_tx;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_rx_found) w_state_next = S_RECV;
            S_RECV: begin
                if ((r_cnt == 6'd0) && !w_rx_sel_soc) w_state_next = S_IDLE;
                else if (r_cnt == LAST_BYTE)          w_state_next = S_CHECK;
            end
            S_CHECK:   w_state_next = (w_hec_rx == r_hdr[4]) ? S_LOOKUP : S_IDLE;
            S_LOOKUP:  w_state_next = S_TX_SEL;
            S_TX_SEL:  w_state_next = w_tx_any ? S_TX_WAIT : S_IDLE;
            S_TX_WAIT: if (tx_clav[r_tx_port]) w_state_next = S_SEND;
            S_SEND:    if (r_cnt == LAST_BYTE) w_state_next = S_TX_SEL;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rx_port <= '0;
            r_rr_ptr  <= '0;
            r_tx_port <= '0;
            r_mask    <= '0;
            r_vpi12   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_rx_found) begin
                        r_rx_port <= w_rx_pick;
                        r_cnt     <= '0;
                        if (int'(w_rx_pick) == NumRx - 1) r_rr_ptr <= '0;
                        else                              r_rr_ptr <= w_rx_pick + 2'd1;
                    end
                end
                S_RECV:   r_cnt <= (r_cnt == LAST_BYTE) ? 6'd0 : r_cnt + 6'd1;
                S_LOOKUP: begin
                    // Sees the table contents from before any CPU write on this same edge.
                    r_mask  <= r_lut[w_vpi8][15:12] & TX_VALID;
                    r_vpi12 <= r_lut[w_vpi8][11:0];
                end
                S_TX_SEL: begin
                    r_tx_port <= w_tx_pick;
                    r_cnt     <= '0;
                end
                S_SEND: begin
                    if (r_cnt == LAST_BYTE) begin
                        r_cnt             <= '0;
                        r_mask[r_tx_port] <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_RECV) begin
            if (r_cnt < HDR_LEN) r_hdr[r_cnt[2:0]] <= w_rx_sel_byte;
            else                 r_pay[w_pay_idx]  <= w_rx_sel_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 256; k++) r_lut[k] <= 16'h0000;
            r_cpu_rdy   <= 1'b0;
            r_cpu_rdata <= 16'h0000;
        end else begin
            r_cpu_rdy <= cpu_sel;
            if (cpu_sel && cpu_wr)  r_lut[cpu_addr] <= cpu_wdata;
            if (cpu_sel && !cpu_wr) r_cpu_rdata     <= r_lut[cpu_addr];
        end
    end

endmodule

// File: tb/tb_squat_switch.sv
// Directed bench for squat_switch: CPU table vectors, then hand-built cell sequences.
module tb_squat_switch;
    localparam int NRX = 4;
    localparam int NTX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [8*NRX-1:0]  rx_data;
    logic [NRX-1:0]    rx_soc, rx_clav, rx_en;
    logic [8*NTX-1:0]  tx_data;
    logic [NTX-1:0]    tx_soc, tx_en, tx_clav;
    logic              cpu_sel, cpu_wr, cpu_rdy;
    logic [7:0]        cpu_addr;
    logic [15:0]       cpu_wdata, cpu_rdata;

    squat_switch #(.NumRx(NRX), .NumTx(NTX)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_soc(rx_soc), .rx_clav(rx_clav), .rx_en(rx_en),
        .tx_data(tx_data), .tx_soc(tx_soc), .tx_en(tx_en), .tx_clav(tx_clav),
        .cpu_sel(cpu_sel), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } cpu_vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] rx_cell [NRX][53];
    bit         rx_pend [NRX];
    bit         rx_socok [NRX];
    int         rx_idx [NRX];
    int         rx_low [NRX];
    int         aborts, rx_stray;

    logic [7:0] tx_q [NTX][$];
    int         tx_first [NTX];
    int         tx_last [NTX];
    int         tx_frame_bad [NTX];
    bit         tx_prev_low [NTX];
    int         overlap;

    logic [7:0] exp_hdr [5];
    logic [7:0] tags [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive the Rx lanes for the next rising edge.
    task automatic tick();
        int nlow;
        @(negedge clk);
        cyc++;
        nlow = 0;
        for (int j = 0; j < NTX; j++) begin
            if (tx_en[j] === 1'b0) begin
                nlow++;
                if (tx_soc[j] !== ((tx_q[j].size() % 53) == 0)) tx_frame_bad[j]++;
                if (tx_q[j].size() == 0) tx_first[j] = cyc;
                tx_q[j].push_back(tx_data[8*j +: 8]);
                tx_last[j]     = cyc;
                tx_prev_low[j] = 1'b1;
            end else begin
                if (tx_prev_low[j] && (tx_q[j].size() % 53) != 0) tx_frame_bad[j]++;
                if (tx_soc[j] !== 1'b0 || tx_data[8*j +: 8] !== 8'h00) tx_frame_bad[j]++;
                tx_prev_low[j] = 1'b0;
            end
        end
        if (nlow > 1) overlap++;
        for (int p = 0; p < NRX; p++) begin
            if (rx_en[p] === 1'b0) begin
                rx_low[p]++;
                if (!rx_pend[p]) begin
                    rx_stray++;
                end else begin
                    rx_data[8*p +: 8] = rx_cell[p][rx_idx[p]];
                    rx_soc[p] = (rx_idx[p] == 0) ? rx_socok[p] : (rx_idx[p] == 30);
                    rx_idx[p]++;
                    if (rx_idx[p] == 53) begin
                        rx_pend[p] = 1'b0;
                        rx_idx[p]  = 0;
                    end
                end
            end else begin
                rx_soc[p] = 1'b0;
                if (rx_idx[p] != 0) begin
                    aborts++;
                    rx_pend[p] = 1'b0;
                    rx_idx[p]  = 0;
                end
            end
            rx_clav[p] = rx_pend[p];
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        for (int j = 0; j < NTX; j++) begin
            tx_q[j].delete();
            tx_first[j] = 0; tx_last[j] = 0; tx_frame_bad[j] = 0; tx_prev_low[j] = 1'b0;
        end
        for (int p = 0; p < NRX; p++) rx_low[p] = 0;
        overlap = 0; aborts = 0; rx_stray = 0;
    endtask

    task automatic load_cell(input int p, input logic [7:0] hec, input logic [7:0] tag, input bit socok);
        rx_cell[p][0] = 8'h00; rx_cell[p][1] = 8'h00; rx_cell[p][2] = 8'h00;
        rx_cell[p][3] = 8'h01; rx_cell[p][4] = hec;
        for (int k = 0; k < 48; k++) rx_cell[p][5+k] = tag + 8'(k);
        rx_socok[p] = socok;
        rx_idx[p]   = 0;
        rx_pend[p]  = 1'b1;
    endtask

    task automatic wait_tx(input int j, input int n, input int budget, input string name);
        int c = 0;
        while (tx_q[j].size() < n && c < budget) begin
            tick();
            c++;
        end
        check(name, tx_q[j].size(), n);
    endtask

    task automatic check_cell(input string name, input int j, input int base, input logic [7:0] tag);
        int nbad = 0;
        int fidx = -1;
        logic [7:0] want, got, fwant, fgot;
        fwant = 8'h00; fgot = 8'h00;
        for (int k = 0; k < 53; k++) begin
            want = (k < 5) ? exp_hdr[k] : tag + 8'(k - 5);
            got  = (base + k < tx_q[j].size()) ? tx_q[j][base+k] : 8'hxx;
            if (got !== want) begin
                nbad++;
                if (fidx < 0) begin fidx = k; fwant = want; fgot = got; end
            end
        end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s: %0d bytes differ, first byte %0d got %h want %h", name, nbad, fidx, fgot, fwant);
        end
        $display("cell %s tx%0d tag=%h checked", name, j, tag);
    endtask

    task automatic cpu_access(input bit wr, input logic [7:0] addr, input logic [15:0] wdata,
                              output logic rdy1, output logic rdy2, output logic [15:0] rdata);
        cpu_sel = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        tick();
        rdy1  = cpu_rdy;
        rdata = cpu_rdata;
        cpu_sel = 1'b0; cpu_wr = 1'b0;
        tick();
        rdy2 = cpu_rdy;
        $display("cpu %s addr=%h wdata=%h rdata=%h", wr ? "wr" : "rd", addr, wdata, rdata);
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [15:0] data);
        logic r1, r2;
        logic [15:0] rd;
        cpu_access(1'b1, addr, data, r1, r2, rd);
    endtask

    function automatic int tx_total();
        int s = 0;
        for (int j = 0; j < NTX; j++) s += tx_q[j].size();
        return s;
    endfunction

    cpu_vec_t cv [8];

    initial begin
        logic        r1, r2;
        logic [15:0] rd;
        int          c, raise_cyc, fb;

        rst = 1'b0; rx_data = '0; rx_soc = '0; rx_clav = '0; tx_clav = 4'hF;
        cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
        for (int p = 0; p < NRX; p++) begin rx_pend[p] = 1'b0; rx_idx[p] = 0; rx_socok[p] = 1'b1; end
        clear_mon();
        exp_hdr[0] = 8'hAB; exp_hdr[1] = 8'hC0; exp_hdr[2] = 8'h00; exp_hdr[3] = 8'h01; exp_hdr[4] = 8'hAA;
        tags[0] = 8'h10; tags[1] = 8'h50; tags[2] = 8'h90; tags[3] = 8'hD0;
        cv[0] = '{1'b1, 8'h05, 16'h3123, 16'h0000};
        cv[1] = '{1'b0, 8'h05, 16'h0000, 16'h3123};
        cv[2] = '{1'b0, 8'h07, 16'h0000, 16'h0000};
        cv[3] = '{1'b1, 8'hFF, 16'h8001, 16'h0000};
        cv[4] = '{1'b0, 8'hFF, 16'h0000, 16'h8001};
        cv[5] = '{1'b1, 8'h00, 16'h1ABC, 16'h0000};
        cv[6] = '{1'b0, 8'h00, 16'h0000, 16'h1ABC};
        cv[7] = '{1'b0, 8'h05, 16'h0000, 16'h3123};

        // Reset state
        run(2);
        check("rst_rx_en", rx_en, 4'hF);
        check("rst_tx_en", tx_en, 4'hF);
        check("rst_tx_soc", tx_soc, 4'h0);
        check("rst_tx_data", tx_data, 32'h0);
        check("rst_cpu_rdy", cpu_rdy, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 16'h0);
        rst = 1'b1;
        run(2);

        // CPU table vectors
        for (int i = 0; i < 8; i++) begin
            cpu_access(cv[i].wr, cv[i].addr, cv[i].wdata, r1, r2, rd);
            check($sformatf("cpu%0d_rdy", i), r1, 1'b1);
            check($sformatf("cpu%0d_rdy_drop", i), r2, 1'b0);
            if (!cv[i].wr) check($sformatf("cpu%0d_rdata", i), rd, cv[i].exp);
        end

        // Basic forward Rx0 -> Tx0
        clear_mon();
        load_cell(0, 8'h52, tags[0], 1'b1);
        wait_tx(0, 53, 300, "fwd_arrive");
        run(10);
        check("fwd_len", tx_q[0].size(), 53);
        check_cell("fwd_cell", 0, 0, tags[0]);
        check("fwd_rx_low", rx_low[0], 53);
        check("fwd_frame", tx_frame_bad[0], 0);
        check("fwd_other_ports", tx_q[1].size() + tx_q[2].size() + tx_q[3].size(), 0);

        // Bad HEC dropped
        clear_mon();
        load_cell(0, 8'h53, tags[0], 1'b1);
        run(250);
        check("badhec_tx", tx_total(), 0);
        check("badhec_rx_low", rx_low[0], 53);
        $display("cell badhec tx_bytes=%0d", tx_total());

        // Missing SOC on byte 0 aborts after one byte
        clear_mon();
        load_cell(0, 8'h52, tags[0], 1'b0);
        run(150);
        check("abort_count", aborts, 1);
        check("abort_rx_low", rx_low[0], 1);
        check("abort_tx", tx_total(), 0);
        $display("cell abort rx_low=%0d", rx_low[0]);

        // Fan-out to all ports, Tx1 stalled
        cpu_write(8'h00, 16'hFABC);
        tx_clav = 4'b1101;
        clear_mon();
        load_cell(0, 8'h52, 8'h20, 1'b1);
        wait_tx(0, 53, 300, "fan_tx0_arrive");
        run(120);
        check("fan_stall_tx1", tx_q[1].size(), 0);
        check("fan_stall_tx2", tx_q[2].size(), 0);
        check("fan_stall_tx3", tx_q[3].size(), 0);
        raise_cyc = cyc;
        tx_clav = 4'hF;
        wait_tx(3, 53, 800, "fan_tx3_arrive");
        run(10);
        for (int j = 0; j < NTX; j++) begin
            check_cell($sformatf("fan_cell%0d", j), j, 0, 8'h20);
            check($sformatf("fan_len%0d", j), tx_q[j].size(), 53);
        end
        check("fan_tx1_after_raise", tx_first[1] > raise_cyc, 1'b1);
        check("fan_gap01", tx_first[1] > tx_last[0] + 1, 1'b1);
        check("fan_gap12", tx_first[2] > tx_last[1] + 1, 1'b1);
        check("fan_gap23", tx_first[3] > tx_last[2] + 1, 1'b1);
        check("fan_overlap", overlap, 0);
        fb = 0;
        for (int j = 0; j < NTX; j++) fb += tx_frame_bad[j];
        check("fan_frame", fb, 0);

        // Round-robin across all Rx ports after a fresh reset
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        cpu_write(8'h00, 16'h1ABC);
        clear_mon();
        for (int p = 0; p < NRX; p++) load_cell(p, 8'h52, tags[p], 1'b1);
        wait_tx(0, 4 * 53, 2000, "rr_arrive");
        run(10);
        for (int p = 0; p < NRX; p++) begin
            check_cell($sformatf("rr_cell%0d", p), 0, 53 * p, tags[p]);
            check($sformatf("rr_rx_low%0d", p), rx_low[p], 53);
        end
        check("rr_frame", tx_frame_bad[0], 0);
        check("rr_stray_rx", rx_stray, 0);

        // Reset in the middle of a received cell
        clear_mon();
        load_cell(0, 8'h52, tags[0], 1'b1);
        c = 0;
        while (rx_idx[0] != 21 && c < 100) begin
            tick();
            c++;
        end
        check("rstmid_reach", rx_idx[0], 21);
        rst = 1'b0;
        tick();
        check("rstmid_rx_en", rx_en, 4'hF);
        check("rstmid_tx_en", tx_en, 4'hF);
        rst = 1'b1;
        run(150);
        check("rstmid_tx", tx_total(), 0);
        check("rstmid_rx_low", rx_low[0], 21);
        cpu_access(1'b0, 8'h00, 16'h0000, r1, r2, rd);
        check("rstmid_lut_cleared", rd, 16'h0000);
        check("rstmid_rdy", r1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/squat_switch.md
# squat_switch

Four-by-four ATM cell switch (parameterizable port counts) between UTOPIA-style receive and transmit cell ports. It accepts 53-byte UNI cells on the Rx ports and checks the header HEC. It translates the 8-bit UNI VPI through a CPU-programmed 256-entry lookup table into a 12-bit NNI VPI plus a forward mask. Each valid cell is re-emitted as an NNI cell, with a recomputed HEC, on every Tx port selected by the mask.

## Interface
- NumRx, 4: receive port count (1..4).
- NumTx, 4: transmit port count (1..4).

Ports (one clock `clk`; reset `rst` is synchronous and active-low):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-low reset.
- rx_data  in  8*NumRx  byte lane per Rx port (port i = bits 8i+7:8i).
- rx_soc  in  NumRx  start-of-cell, high with byte 0.
- rx_clav  in  NumRx  Rx port has a cell available.
- rx_en  out  NumRx  active-low read enable per Rx port.
- tx_data  out  8*NumTx  byte lane per Tx port.
- tx_soc  out  NumTx  start-of-cell, high with byte 0.
- tx_en  out  NumTx  active-low write enable per Tx port.
- tx_clav  in  NumTx  Tx port can accept a cell.
- cpu_sel  in  1  CPU access strobe.
- cpu_wr  in  1  1 = write, 0 = read (qualified by cpu_sel).
- cpu_addr  in  8  lookup-table index (UNI VPI).
- cpu_wdata  in  16  [11:0] NNI VPI, [15:12] forward mask (bit j = Tx port j; bits ≥ NumTx ignored).
- cpu_rdata  out  16  read data, same format.
- cpu_rdy  out  1  one-cycle access-complete pulse.

## Operation
- UNI header: byte0 = {GFC[3:0], VPI[7:4]}; byte1 = {VPI[3:0], VCI[15:12]}; byte2 = VCI[11:4]; byte3 = {VCI[3:0], PT[2:0], CLP}; byte4 = HEC; bytes 5..52 = payload.
- NNI header: byte0 = VPI12[11:4]; byte1 = {VPI12[3:0], VCI[15:12]}; bytes 2..3 unchanged; byte4 = new HEC; payload unchanged.
- HEC = CRC-8, polynomial x^8+x^2+x+1, initial value 0, computed MSB-first over bytes 0..3, then XOR 0x55.
- State machine, one cell in flight:
  - IDLE: pick the next Rx port with rx_clav=1, round-robin starting after the last-served port.
  - RECV: collect 53 bytes.
  - CHECK: compare the HEC; on mismatch, drop the cell and go to IDLE.
  - LOOKUP: read lut[VPI8].
  - If the mask is 0, drop the cell and go to IDLE.
  - Otherwise SEND: for each mask bit, ascending port order, wait for tx_clav[j]=1, then transmit 53 bytes. Return to IDLE after the last selected port.
- Rx protocol:
  - The switch holds rx_en[i]=0 for exactly 53 consecutive cycles and samples rx_data/rx_soc at each edge where rx_en[i] is low.
  - If rx_soc=0 on byte 0, abort: rx_en goes high and the switch returns to IDLE.
  - If rx_soc=1 on bytes 1..52, the flag is ignored.
- Tx protocol: the switch drives tx_en[j]=0 for 53 consecutive cycles, with tx_soc[j]=1 only on byte 0. tx_data[j] is valid while tx_en[j]=0.
- CPU access: when cpu_sel=1, a write stores cpu_wdata into lut[cpu_addr] and a read loads cpu_rdata. cpu_rdy=1 on the following cycle.
  - A CPU write in the same cycle as LOOKUP: the lookup sees the old entry.
  - cpu_sel held high issues an access every cycle.

## Timing
- Reset values:
  - rx_en and tx_en all 1.
  - tx_soc = 0, tx_data = 0.
  - cpu_rdy = 0, cpu_rdata = 0.
  - All 256 lut entries = 0 (cells dropped until programmed).
  - Round-robin pointer = port 0.
- IDLE → rx_en low: 1 cycle after rx_clav is sampled high.
- Last Rx byte → CHECK: 1 cycle. CHECK → LOOKUP: 1 cycle. LOOKUP → first tx_en low: ≥1 cycle, plus any tx_clav wait.
- Between consecutive selected Tx ports: at least 1 idle cycle with tx_en high.
- rx_clav/tx_clav are sampled only in IDLE/wait states. Deassertion mid-transfer is ignored; a started transfer always completes 53 bytes.
- Reset mid-cell: on the next edge all enables go high and the cell is discarded.

## Test plan
- Program lut[0x00] = 0x1ABC (fwd=port0, VPI=0xABC). Send UNI cell 00 00 00 01 52 + payload on Rx0 → Tx0 emits AB C0 00 01 <new HEC> + identical payload, tx_soc on byte 0, 53 enable cycles.
- Same cell with HEC byte 0x53 → no tx_en activity; switch returns to IDLE.
- lut[0x00] fwd=0xF → cell appears on Tx0, Tx1, Tx2, Tx3 in order; holding tx_clav[1]=0 stalls delivery until it rises.
- Cells offered on all four Rx ports at once → served Rx0, Rx1, Rx2, Rx3 (round-robin), each forwarded intact.
- CPU write addr 0x05 data 0x3123, then read addr 0x05 → cpu_rdata = 0x3123, cpu_rdy one cycle after each access.
- rst=0 asserted at Rx byte 20 → rx_en high next cycle; no Tx output; lut cleared (read returns 0).
